// File: rtl/jt12_kon_wr_pkg.sv
// ----------------------------------------------------------------------------
// jt12_kon_wr_pkg
// Shared constants and helpers for the key-on write front end and the slot
// counter:
//   KON_REG        - CPU register address that carries key-on commands
//   kon_op_e       - slot operator encoding presented on next_op
//   channel helpers- valid code check, last code and successor per num_ch
//   rev_load       - revolution counter load value per num_ch
// ----------------------------------------------------------------------------
package jt12_kon_wr_pkg;

    localparam logic [7:0] KON_REG = 8'h28;

    // Slot order within one operator pass is S1, S3, S2, S4.
    typedef enum logic [1:0] {
        OP_S1 = 2'd0,
        OP_S3 = 2'd1,
        OP_S2 = 2'd2,
        OP_S4 = 2'd3
    } kon_op_e;

    localparam logic [2:0] CH_LAST_6  = 3'd6;
    localparam logic [2:0] CH_LAST_3  = 3'd2;
    localparam logic [4:0] REV_LOAD_6 = 5'd23;  // 24 slots per revolution
    localparam logic [4:0] REV_LOAD_3 = 5'd11;  // 12 slots per revolution

    function automatic logic [2:0] ch_last(input int unsigned num_ch);
        return (num_ch == 3) ? CH_LAST_3 : CH_LAST_6;
    endfunction

    function automatic logic [4:0] rev_load(input int unsigned num_ch);
        return (num_ch == 3) ? REV_LOAD_3 : REV_LOAD_6;
    endfunction

    // 6-ch codes are 0,1,2,4,5,6; 3-ch codes are 0,1,2.
    function automatic logic ch_valid(input logic [2:0] code, input int unsigned num_ch);
        if (num_ch == 3)
            return code <= CH_LAST_3;
        return (code != 3'd3) && (code != 3'd7);
    endfunction

    function automatic logic [2:0] ch_next(input logic [2:0] code, input int unsigned num_ch);
        if (code == ch_last(num_ch))
            return 3'd0;
        if (code == 3'd2)
            return 3'd4;   // code 3 is a hole in the channel map
        return code + 3'd1;
    endfunction

endpackage

// File: rtl/jt12_kon_slot.sv
// ----------------------------------------------------------------------------
// jt12_kon_slot
// Operator/channel slot counter. Advances one slot per enabled cycle; the
// channel code walks the valid code list and the operator steps at each wrap.
//   clk_i      in   system clock
//   rst_i      in   asynchronous active-high reset
//   clk_en_i   in   slot advance enable
//   next_op_o  out  current slot operator (0=S1, 1=S3, 2=S2, 3=S4)
//   next_ch_o  out  current slot channel code
// ----------------------------------------------------------------------------
import jt12_kon_wr_pkg::*;

module jt12_kon_slot #(
    parameter int unsigned num_ch = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_en_i,
    output logic [1:0] next_op_o,
    output logic [2:0] next_ch_o
);

    kon_op_e    op_q, op_d;
    logic [2:0] ch_q, ch_d;

    always_comb begin
        op_d = op_q;
        ch_d = ch_q;
        if (clk_en_i) begin
            ch_d = ch_next(ch_q, num_ch);
            if (ch_q == ch_last(num_ch))
                op_d = kon_op_e'(op_q + 2'd1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q <= OP_S1;
            ch_q <= '0;
        end else begin
            op_q <= op_d;
            ch_q <= ch_d;
        end
    end

    assign next_op_o = op_q;
    assign next_ch_o = ch_q;

endmodule

// File: rtl/jt12_kon_wr.sv
// ----------------------------------------------------------------------------
// jt12_kon_wr
// Key-on write front end. Decodes CPU writes to register 0x28, holds one
// pending request and presents the active request to the key-on block for
// exactly one slot revolution. Also owns the slot counter.
//   rst       in   asynchronous active-high reset
//   clk       in   system clock
//   clk_en    in   slot advance enable
//   wr        in   CPU write strobe (sampled every clk)
//   a0        in   0 = address write, 1 = data write
//   din       in   CPU write data
//   next_op   out  current slot operator
//   next_ch   out  current slot channel code
//   keyon_op  out  active request operator mask {S4,S3,S2,S1}
//   keyon_ch  out  active request channel code
//   up_keyon  out  active request valid
//   busy      out  request active or pending
//   lost      out  sticky: a pending request was overwritten
// ----------------------------------------------------------------------------
import jt12_kon_wr_pkg::*;

module jt12_kon_wr #(
    parameter int unsigned num_ch = 6
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       clk_en,
    input  logic       wr,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [1:0] next_op,
    output logic [2:0] next_ch,
    output logic [3:0] keyon_op,
    output logic [2:0] keyon_ch,
    output logic       up_keyon,
    output logic       busy,
    output logic       lost
);

    logic [7:0] addr_q, addr_d;
    logic       pend_v_q, pend_v_d;
    logic [3:0] pend_op_q, pend_op_d;
    logic [2:0] pend_ch_q, pend_ch_d;
    logic [3:0] act_op_q, act_op_d;
    logic [2:0] act_ch_q, act_ch_d;
    logic       up_q, up_d;
    logic [4:0] cnt_q, cnt_d;
    logic       lost_q, lost_d;

    logic       capture;
    logic       xfer;

    jt12_kon_slot #(
        .num_ch (num_ch)
    ) u_slot (
        .clk_i     (clk),
        .rst_i     (rst),
        .clk_en_i  (clk_en),
        .next_op_o (next_op),
        .next_ch_o (next_ch)
    );

    assign capture = wr & a0 & (addr_q == KON_REG) & ch_valid(din[2:0], num_ch);
    // Pending moves to active when the slot is free or the active request is
    // on its last enabled slot, so back-to-back requests leave no gap.
    assign xfer    = clk_en & pend_v_q & (~up_q | (cnt_q == '0));

    always_comb begin
        addr_d    = addr_q;
        pend_v_d  = pend_v_q;
        pend_op_d = pend_op_q;
        pend_ch_d = pend_ch_q;
        act_op_d  = act_op_q;
        act_ch_d  = act_ch_q;
        up_d      = up_q;
        cnt_d     = cnt_q;
        lost_d    = lost_q;

        if (wr && !a0)
            addr_d = din;

        if (clk_en && up_q) begin
            if (cnt_q == '0)
                up_d = 1'b0;
            else
                cnt_d = cnt_q - 5'd1;
        end

        // Transfer uses the old pending contents; a capture in the same cycle
        // refills the pending slot below without counting as a loss.
        if (xfer) begin
            act_op_d = pend_op_q;
            act_ch_d = pend_ch_q;
            up_d     = 1'b1;
            cnt_d    = rev_load(num_ch);
            pend_v_d = 1'b0;
        end

        if (capture) begin
            if (pend_v_q && !xfer)
                lost_d = 1'b1;
            pend_v_d  = 1'b1;
            pend_op_d = din[7:4];
            pend_ch_d = din[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            pend_v_q  <= 1'b0;
            pend_op_q <= '0;
            pend_ch_q <= '0;
            act_op_q  <= '0;
            act_ch_q  <= '0;
            up_q      <= 1'b0;
            cnt_q     <= '0;
            lost_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            pend_v_q  <= pend_v_d;
            pend_op_q <= pend_op_d;
            pend_ch_q <= pend_ch_d;
            act_op_q  <= act_op_d;
            act_ch_q  <= act_ch_d;
            up_q      <= up_d;
            cnt_q     <= cnt_d;
            lost_q    <= lost_d;
        end
    end

    assign keyon_op = act_op_q;
    assign keyon_ch = act_ch_q;
    assign up_keyon = up_q;
    assign busy     = pend_v_q | up_q;
    assign lost     = lost_q;

endmodule

// File: tb/tb_jt12_kon_wr.sv
module tb_jt12_kon_wr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       wr = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] next_op;
    logic [2:0] next_ch;
    logic [3:0] keyon_op;
    logic [2:0] keyon_ch;
    logic       up_keyon;
    logic       busy;
    logic       lost;

    always #5 clk = ~clk;

    jt12_kon_wr #(.num_ch(6)) dut (
        .rst      (rst),
        .clk      (clk),
        .clk_en   (clk_en),
        .wr       (wr),
        .a0       (a0),
        .din      (din),
        .next_op  (next_op),
        .next_ch  (next_ch),
        .keyon_op (keyon_op),
        .keyon_ch (keyon_ch),
        .up_keyon (up_keyon),
        .busy     (busy),
        .lost     (lost)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Reference model: slot position as a plain count of enabled cycles,
    // active request as number of enabled slots still to be shown.
    localparam int CHS [6] = '{0, 1, 2, 4, 5, 6};
    localparam int REV = 24;
    int unsigned m_slot;
    int          m_left;
    bit          m_pend;
    logic [7:0]  m_pend_val;
    logic [7:0]  m_addr;
    logic [3:0]  m_kop;
    logic [2:0]  m_kch;
    bit          m_lost;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_left = 0; m_pend = 0; m_pend_val = '0;
        m_addr = '0; m_kop = '0; m_kch = '0; m_lost = 0;
    endtask

    task automatic model_step();
        bit valid, cap, xfer;
        valid = 0;
        foreach (CHS[i]) if (int'(din[2:0]) == CHS[i]) valid = 1;
        cap  = wr && a0 && (m_addr == 8'h28) && valid;
        xfer = clk_en && m_pend && (m_left <= 1);
        if (clk_en) begin
            if (m_left > 0) m_left--;
            if (xfer) begin
                m_left = REV;
                m_kop  = m_pend_val[7:4];
                m_kch  = m_pend_val[2:0];
            end
            m_slot++;
        end
        if (cap) begin
            if (m_pend && !xfer) m_lost = 1;
            m_pend     = 1;
            m_pend_val = din;
        end else if (xfer) begin
            m_pend = 0;
        end
        if (wr && !a0) m_addr = din;
    endtask

    // Compare process: every negedge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("next_op", 8'(next_op), 8'((m_slot / 6) % 4));
            chk("next_ch", 8'(next_ch), 8'(CHS[m_slot % 6]));
            chk("keyon_op", 8'(keyon_op), 8'(m_kop));
            chk("keyon_ch", 8'(keyon_ch), 8'(m_kch));
            chk("up_keyon", 8'(up_keyon), 8'(m_left > 0));
            chk("busy", 8'(busy), 8'(m_pend || m_left > 0));
            chk("lost", 8'(lost), 8'(m_lost));
        end
    end

    task automatic tick(input logic w, input logic a, input logic [7:0] d, input logic e);
        wr = w; a0 = a; din = d; clk_en = e;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        wr = 1'b0;
    endtask

    task automatic kon_write(input logic [7:0] d);
        tick(1'b1, 1'b0, 8'h28, 1'b1);
        tick(1'b1, 1'b1, d, 1'b1);
    endtask

    initial begin
        int hi, rises;
        logic prev;
        model_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk_on = 1'b1;
        rst = 1'b0;

        // Slot sequence from reset
        chk("rst_up", 8'(up_keyon), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        repeat (30) tick(0, 0, 0, 1);
        chk("slot30_op", 8'(next_op), 8'h1);
        chk("slot30_ch", 8'(next_ch), 8'h0);
        chk("slot30_lost", 8'(lost), 8'h0);

        // Single request 0xF5
        kon_write(8'hF5);
        chk("cap_busy", 8'(busy), 8'h1);
        hi = 0; prev = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 0, 1);
            if (up_keyon) hi++;
            if (prev && !up_keyon) chk("fall_busy", 8'(busy), 8'h0);
            prev = up_keyon;
        end
        chk("f5_hi", 8'(hi), 8'd24);
        chk("f5_ch", 8'(keyon_ch), 8'h5);
        chk("f5_op", 8'(keyon_op), 8'hF);

        // Invalid channel codes and wrong address
        kon_write(8'h13);
        chk("inv13_busy", 8'(busy), 8'h0);
        kon_write(8'hF7);
        chk("inv17_busy", 8'(busy), 8'h0);
        tick(1, 0, 8'h27, 1);
        tick(1, 1, 8'hF1, 1);
        chk("addr27_busy", 8'(busy), 8'h0);
        repeat (3) tick(0, 0, 0, 1);
        chk("inv_up", 8'(up_keyon), 8'h0);

        // Back-to-back requests
        kon_write(8'hF0);
        hi = 0; rises = 0; prev = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 6) tick(1, 1, 8'h01, 1);
            else        tick(0, 0, 0, 1);
            if (up_keyon) hi++;
            if (up_keyon && !prev) rises++;
            prev = up_keyon;
        end
        chk("b2b_hi", 8'(hi), 8'd48);
        chk("b2b_rises", 8'(rises), 8'd1);
        chk("b2b_lost", 8'(lost), 8'h0);
        chk("b2b_ch", 8'(keyon_ch), 8'h1);

        // Overwrites of a pending request during an active one
        kon_write(8'hF0);
        tick(0, 0, 0, 1);
        tick(1, 1, 8'h10, 1);
        tick(1, 1, 8'h21, 1);
        chk("ovr_lost", 8'(lost), 8'h1);
        tick(1, 1, 8'h42, 1);
        repeat (60) tick(0, 0, 0, 1);
        chk("ovr_ch", 8'(keyon_ch), 8'h2);
        chk("ovr_op", 8'(keyon_op), 8'h4);
        chk("ovr_idle", 8'(up_keyon), 8'h0);

        // clk_en low: capture happens, transfer waits
        tick(1, 1, 8'h31, 0);
        repeat (4) tick(0, 0, 0, 0);
        chk("frz_busy", 8'(busy), 8'h1);
        chk("frz_up", 8'(up_keyon), 8'h0);
        tick(0, 0, 0, 1);
        chk("frz_go", 8'(up_keyon), 8'h1);
        chk("frz_ch", 8'(keyon_ch), 8'h1);
        chk("frz_op", 8'(keyon_op), 8'h3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic w, a, e;
            logic [7:0] d;
            e = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 11) == 0);
            a = ($urandom_range(0, 3) != 0);
            if (!a) d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h28;
            else    d = 8'($urandom);
            tick(w, a, d, e);
        end

        // Reset in the middle of a request
        repeat (40) tick(0, 0, 0, 1);
        kon_write(8'hA6);
        repeat (5) tick(0, 0, 0, 1);
        chk("pre_rst_up", 8'(up_keyon), 8'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_up", 8'(up_keyon), 8'h0);
        chk("async_busy", 8'(busy), 8'h0);
        tick(0, 0, 0, 1);
        rst = 1'b0;
        chk("post_rst_op", 8'(next_op), 8'h0);
        chk("post_rst_ch", 8'(next_ch), 8'h0);
        tick(0, 0, 0, 1);
        chk("post_rst_ch1", 8'(next_ch), 8'h1);
        repeat (3) tick(0, 0, 0, 1);

        @(posedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
